// File: rtl/serial_nibble_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_nibble_rx_pkg
// Shared definitions for the serial nibble receiver: FSM state encoding,
// the default word width and a helper that sizes the data-bit counter.
// -----------------------------------------------------------------------------
package serial_nibble_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } srx_state_t;

  localparam int unsigned SRX_WIDTH_DEFAULT = 4;

  // The counter only has to index data bits 0..width-1; keep at least one bit
  // so a WIDTH=1 build still has a legal vector.
  function automatic int unsigned srx_cnt_bits(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_nibble_rx_shift_reg.sv
// -----------------------------------------------------------------------------
// srx_shift_reg
// WIDTH-bit shift-in register. New bits enter at the MSB and move toward the
// LSB, so after WIDTH shifts of an LSB-first stream the first bit received
// sits in bit 0.
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_clr      synchronous clear (wins over shift)
//   i_shift_en shift i_bit in on this edge
//   i_bit      serial bit to shift in
//   o_data     register contents
// -----------------------------------------------------------------------------
module srx_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_data;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      w_next[i] = r_data[i+1];
    end
    w_next[WIDTH-1] = i_bit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_shift_en) begin
      r_data <= w_next;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/serial_nibble_rx.sv
// -----------------------------------------------------------------------------
// serial_nibble_rx
// Deserialises a framed serial stream (start 0, WIDTH data bits LSB first,
// parity, stop 1) into one WIDTH-bit word. Good frames update o_nib with a
// one-cycle o_load strobe for the downstream enabled register; bad frames
// raise one-cycle error pulses and never load.
//
// state  | meaning
// IDLE   | line idle, waiting for a sampled start bit (0)
// DATA   | collecting WIDTH data bits, r_cnt = bits taken so far
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit; frame evaluated on this sample
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous active-high reset
//   i_din          serial data bit
//   i_din_valid    i_din is sampled only when this is 1
//   o_nib          last good word (downstream D)
//   o_load         one-cycle strobe when o_nib updates (downstream En)
//   o_busy         1 whenever the FSM is not in IDLE
//   o_err_parity   one-cycle pulse, parity mismatch in the frame just ended
//   o_err_stop     one-cycle pulse, stop bit sampled as 0
//   o_frames_ok    good-frame count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module serial_nibble_rx
  import serial_nibble_rx_pkg::*;
#(
  parameter int unsigned WIDTH      = SRX_WIDTH_DEFAULT,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_din,
  input  logic             i_din_valid,
  output logic [WIDTH-1:0] o_nib,
  output logic             o_load,
  output logic             o_busy,
  output logic             o_err_parity,
  output logic             o_err_stop,
  output logic [CNT_W-1:0] o_frames_ok
);

  localparam int unsigned      CW       = srx_cnt_bits(WIDTH);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

  srx_state_t       r_state;
  srx_state_t       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic             r_par_bit;
  logic [WIDTH-1:0] r_nib;
  logic             r_load;
  logic             r_err_parity;
  logic             r_err_stop;
  logic [CNT_W-1:0] r_frames_ok;

  logic             w_clr;
  logic             w_shift;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_par_cap;
  logic             w_eval;
  logic [WIDTH-1:0] w_data;
  logic             w_par_good;
  logic             w_good;

  srx_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .i_clk      (i_clk),
    .i_rst      (i_reset),
    .i_clr      (w_clr),
    .i_shift_en (w_shift),
    .i_bit      (i_din),
    .o_data     (w_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_shift      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_par_cap    = 1'b0;
    w_eval       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_din_valid && !i_din) begin
          w_next_state = DATA;
          w_clr        = 1'b1;
          w_cnt_clr    = 1'b1;
        end
      end
      DATA: begin
        if (i_din_valid) begin
          w_shift   = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_next_state = PARITY;
          end
        end
      end
      PARITY: begin
        if (i_din_valid) begin
          w_par_cap    = 1'b1;
          w_next_state = STOP;
        end
      end
      STOP: begin
        if (i_din_valid) begin
          w_eval       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Combined XOR over data and parity bit must equal the parity sense.
  assign w_par_good = ((^w_data) ^ r_par_bit) == PARITY_ODD;
  assign w_good     = w_par_good && i_din;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_par_bit    <= 1'b0;
      r_nib        <= '0;
      r_load       <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_stop   <= 1'b0;
      r_frames_ok  <= '0;
    end else begin
      r_load       <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_stop   <= 1'b0;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_par_cap) begin
        r_par_bit <= i_din;
      end
      if (w_eval) begin
        r_load       <= w_good;
        r_err_parity <= !w_par_good;
        r_err_stop   <= !i_din;
        if (w_good) begin
          r_nib       <= w_data;
          r_frames_ok <= r_frames_ok + CNT_W'(1);
        end
      end
    end
  end

  assign o_nib        = r_nib;
  assign o_load       = r_load;
  assign o_busy       = (r_state != IDLE);
  assign o_err_parity = r_err_parity;
  assign o_err_stop   = r_err_stop;
  assign o_frames_ok  = r_frames_ok;

endmodule

// File: doc/serial_nibble_rx.md
Name: serial_nibble_rx

Overview:
Upstream stage of the 4-bit enabled D register. It deserialises a framed serial bit stream into one WIDTH-bit word, checks parity and stop framing, and presents the word on nib with a one-cycle load strobe. The nib and load outputs wire directly to the register's D and En inputs. Bad frames are flagged and never loaded.

Parameters:
WIDTH, 4, data bits per frame; equals the downstream register width.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity over the data bits plus the parity bit.
CNT_W, 8, width of the good-frame counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
din  input  1  serial data bit.
din_valid  input  1  din is sampled only on edges where this is 1; otherwise the FSM holds.
nib  output  WIDTH  last good word; drives downstream D.
load  output  1  one-cycle strobe when nib takes a new value; drives downstream En.
busy  output  1  1 whenever the state is not IDLE.
err_parity  output  1  one-cycle pulse; parity mismatch in the frame just ended.
err_stop  output  1  one-cycle pulse; stop bit sampled as 0.
frames_ok  output  CNT_W  count of good frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: nib=0, load=0, busy=0, err_parity=0, err_stop=0, frames_ok=0, state=IDLE, bit counter=0.
- Frame format, in sampled (din_valid=1) bits only:
  - start bit 0;
  - WIDTH data bits, LSB first;
  - one parity bit;
  - one stop bit 1.
- FSM states:
  - IDLE: a sampled din=0 moves to DATA with counter=0. A sampled din=1 is ignored (line idle).
  - DATA: each sampled bit shifts into the shift register at bit position counter, then counter increments. After WIDTH samples, move to PARITY.
  - PARITY: the sampled bit is captured; move to STOP.
  - STOP: on the sampled bit, return to IDLE and evaluate the frame.
- Gaps: din_valid=0 cycles hold state, counter and shift register in every state. There is no timeout.
- Frame evaluation, registered on the STOP sample edge:
  - Parity is good when XOR(data bits, parity bit) == PARITY_ODD.
  - Good frame (parity good and stop=1): nib <= shift register, load=1, frames_ok += 1.
  - Bad parity: err_parity=1.
  - Stop bit = 0: err_stop=1.
  - Both faults may assert together. On any error, nib and frames_ok are unchanged and load=0.
- Latency: load, err_* and the new nib are visible in the cycle immediately after the stop-bit sampling edge. load and err_* are high for exactly one cycle.
- busy: combinational from state; 0 in IDLE, including the load cycle.
- Back-to-back frames: a start bit sampled in the same cycle that load is high is accepted. There are no dead cycles between frames.
- Reset asserted mid-frame: the partial frame is discarded, the FSM returns to IDLE and outputs take their reset values. No load or error pulse is produced.
- frames_ok wraps from 2^CNT_W-1 to 0 silently.
- Data bits are always WIDTH wide. Parity is computed as a reduction XOR over WIDTH+1 bits.

Decomposition:
- Shared package (or include file) holds:
  - state encoding constants IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3;
  - default WIDTH=4.
- One natural sub-module: srx_shift_reg. It is a WIDTH-bit shift-in register with shift enable and synchronous clear, plus asynchronous reset. The FSM, counter and checks stay in the top module.

Test Plan:
- Good frame 0xA, even parity: sampled bits 0,0,1,0,1,0,1 -> one cycle later load=1, nib=4'b1010, frames_ok=1, err_*=0. load=0 on the next cycle.
- Parity error: 0,0,1,0,1,1,1 -> err_parity=1 for one cycle, load=0, nib stays 4'b1010, frames_ok stays 1.
- Stop error plus gaps: frame for 0xF (0,1,1,1,1,0,0) with din_valid=0 for 3 cycles between each bit -> busy=1 throughout, err_stop=1 only, nib unchanged.
- Back-to-back: two frames 0x3 then 0xC with no idle gap, start bit coincident with the first load -> load pulses twice, nib=4'b0011 then 4'b1100, frames_ok +2.
- Reset mid-frame: assert reset after the 2nd data bit of 0x5 -> all outputs 0 immediately, no pulse. Then a clean 0x5 frame loads nib=4'b0101.
- PARITY_ODD=1 instance: frame 0x1 with parity bit 0 -> load, nib=4'b0001. The same frame with parity bit 1 -> err_parity.
